// File: rtl/cl_capture_sched_pkg.sv
// Shared encodings for the Camera Link capture scheduler.
// Word layout and state codes used by the bus side and the PC decoder.
package cl_capture_sched_pkg;

  localparam int N_FRAME_SIZE_DEF = 20;
  localparam int N_LINE_SIZE_DEF  = 12;
  localparam int N_CLK_SIZE_DEF   = 10;
  localparam int DATA_W_DEF       = 80;

  localparam int FLAGS_W         = 6;
  localparam int FLG_FRAME_FIRST = 5;
  localparam int FLG_LINE_FIRST  = 4;
  localparam int FLG_LAST_FRAME  = 3;
  localparam int FLG_OVERFLOW    = 2;

  localparam int OFS_DATA  = 0;
  localparam int OFS_FLAGS = OFS_DATA + DATA_W_DEF;
  localparam int OFS_CLK   = OFS_FLAGS + FLAGS_W;
  localparam int OFS_LINE  = OFS_CLK + N_CLK_SIZE_DEF;
  localparam int OFS_FRAME = OFS_LINE + N_LINE_SIZE_DEF;
  localparam int OUT_W_DEF = OFS_FRAME + N_FRAME_SIZE_DEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_WAIT_FV = 3'd2,
    ST_SKIP    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic [FLAGS_W-1:0] mk_flags(
    input logic frame_first,
    input logic line_first,
    input logic last_frame,
    input logic ovf
  );
    logic [FLAGS_W-1:0] f;
    f = '0;
    f[FLG_FRAME_FIRST] = frame_first;
    f[FLG_LINE_FIRST]  = line_first;
    f[FLG_LAST_FRAME]  = last_frame;
    f[FLG_OVERFLOW]    = ovf;
    return f;
  endfunction

endpackage

// File: rtl/cl_timing_cnt.sv
// Camera Link fval/lval edge detection plus line and beat counters.
// Reusable wherever the CL raster position is needed.
module cl_timing_cnt
  import cl_capture_sched_pkg::*;
#(
  parameter int N_LINE_SIZE = N_LINE_SIZE_DEF,
  parameter int N_CLK_SIZE  = N_CLK_SIZE_DEF
) (
  input  logic                   cl_clk,
  input  logic                   reset,
  input  logic                   cl_fval,
  input  logic                   cl_lval,
  output logic                   fval_rise,
  output logic                   fval_fall,
  output logic                   lval_fall,
  output logic [N_LINE_SIZE-1:0] line_idx,
  output logic [N_CLK_SIZE-1:0]  clk_idx
);

  localparam logic [N_LINE_SIZE-1:0] LINE_ONE = 1;
  localparam logic [N_CLK_SIZE-1:0]  CLK_ONE  = 1;

  logic fval_d;
  logic lval_d;

  assign fval_rise = cl_fval & ~fval_d;
  assign fval_fall = ~cl_fval & fval_d;
  assign lval_fall = ~cl_lval & lval_d;

  // one-cycle delayed copies of the valid strobes
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      fval_d <= 1'b0;
      lval_d <= 1'b0;
    end else begin
      fval_d <= cl_fval;
      lval_d <= cl_lval;
    end
  end

  // line index: restarts per frame, steps at each line end
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset)
      line_idx <= '0;
    else if (fval_rise)
      line_idx <= '0;
    else if (lval_fall)
      line_idx <= line_idx + LINE_ONE;
  end

  // beat index within a line; wraps silently on long lines
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset)
      clk_idx <= '0;
    else if (!cl_lval)
      clk_idx <= '0;
    else
      clk_idx <= clk_idx + CLK_ONE;
  end

endmodule

// File: rtl/cl_capture_sched.sv
// Frame capture scheduler: gates CL beats into tagged FIFO words,
// with decimation, almost-full frame drop, abort and overflow status.
module cl_capture_sched
  import cl_capture_sched_pkg::*;
#(
  parameter int N_FRAME_SIZE = N_FRAME_SIZE_DEF,
  parameter int N_LINE_SIZE  = N_LINE_SIZE_DEF,
  parameter int N_CLK_SIZE   = N_CLK_SIZE_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic                    reset,
  input  logic                    cl_clk,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [N_FRAME_SIZE-1:0] cmd_n_frames,
  input  logic [N_LINE_SIZE-1:0]  cmd_line_first,
  input  logic [N_LINE_SIZE-1:0]  cmd_line_last,
  input  logic [3:0]              cmd_decim,
  input  logic                    abort,
  input  logic                    cl_fval,
  input  logic                    cl_lval,
  input  logic [DATA_W-1:0]       cl_data,
  input  logic                    fifo_afull,
  input  logic                    fifo_full,
  output logic [N_FRAME_SIZE+N_LINE_SIZE+N_CLK_SIZE+FLAGS_W+DATA_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    done,
  output logic                    aborted,
  output logic                    busy,
  output logic [15:0]             drop_cnt,
  output logic                    overflow
);

  localparam logic [N_FRAME_SIZE-1:0] FRAME_ONE = 1;

  state_t state;
  state_t state_nxt;
  state_t start_st;

  logic [N_FRAME_SIZE-1:0] n_frames_q;
  logic [N_LINE_SIZE-1:0]  line_first_q;
  logic [N_LINE_SIZE-1:0]  line_last_q;
  logic [3:0]              decim_q;
  logic [N_FRAME_SIZE-1:0] frame_idx;
  logic [3:0]              decim_cnt;
  logic                    first_pend;
  logic                    aborted_q;

  logic fval_rise;
  logic fval_fall;
  logic lval_fall;
  logic [N_LINE_SIZE-1:0] line_idx;
  logic [N_CLK_SIZE-1:0]  clk_idx;

  logic accept;
  logic frame_start;
  logic frame_inc;
  logic abort_hit;
  logic skip_dec;
  logic skip_drop;
  logic take;
  logic last_frame;
  logic in_win;
  logic cap_word;
  logic ovf_now;
  logic [FLAGS_W-1:0] flags;

  cl_timing_cnt #(
    .N_LINE_SIZE (N_LINE_SIZE),
    .N_CLK_SIZE  (N_CLK_SIZE)
  ) u_timing (
    .cl_clk    (cl_clk),
    .reset     (reset),
    .cl_fval   (cl_fval),
    .cl_lval   (cl_lval),
    .fval_rise (fval_rise),
    .fval_fall (fval_fall),
    .lval_fall (lval_fall),
    .line_idx  (line_idx),
    .clk_idx   (clk_idx)
  );

  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) || aborted_q;
  assign aborted   = aborted_q;

  assign skip_dec   = (decim_cnt != 4'd0);
  assign skip_drop  = !skip_dec && fifo_afull;
  assign take       = !skip_dec && !fifo_afull;
  assign start_st   = take ? ST_CAPTURE : ST_SKIP;
  assign last_frame = (frame_idx + FRAME_ONE) == n_frames_q;
  assign in_win     = (line_first_q <= line_idx) &&
                      (line_idx <= line_last_q);
  assign cap_word   = (state == ST_CAPTURE) && cl_lval &&
                      in_win && !abort;
  // fifo_full is judged when the word is formed, so the word itself
  // can carry the overflow flag it caused
  assign ovf_now    = overflow | (cap_word & fifo_full);
  assign flags      = mk_flags(first_pend, clk_idx == '0,
                               last_frame, ovf_now);

  // state register
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    frame_start = 1'b0;
    frame_inc   = 1'b0;
    abort_hit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          state_nxt = (cmd_n_frames == '0) ? ST_DONE : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!cl_fval)
          state_nxt = ST_WAIT_FV;
      end
      ST_WAIT_FV: begin
        if (fval_rise) begin
          frame_start = 1'b1;
          state_nxt   = start_st;
        end
      end
      ST_SKIP: begin
        if (fval_fall) begin
          state_nxt = ST_WAIT_FV;
        end else if (fval_rise) begin
          frame_start = 1'b1;
          state_nxt   = start_st;
        end
      end
      ST_CAPTURE: begin
        // a rise here means the fall was missed: end and restart
        if (fval_fall || fval_rise) begin
          frame_inc = 1'b1;
          if (last_frame) begin
            state_nxt = ST_DONE;
          end else if (fval_rise) begin
            frame_start = 1'b1;
            state_nxt   = start_st;
          end else begin
            state_nxt = ST_WAIT_FV;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) begin
      state_nxt   = ST_IDLE;
      abort_hit   = 1'b1;
      frame_start = 1'b0;
      frame_inc   = 1'b0;
    end
  end

  // command latch, frame bookkeeping and drop accounting
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      n_frames_q   <= '0;
      line_first_q <= '0;
      line_last_q  <= '0;
      decim_q      <= '0;
      frame_idx    <= '0;
      decim_cnt    <= '0;
      drop_cnt     <= '0;
      first_pend   <= 1'b0;
      aborted_q    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
      overflow  <= accept ? 1'b0 : ovf_now;
      if (accept) begin
        n_frames_q   <= cmd_n_frames;
        line_first_q <= cmd_line_first;
        line_last_q  <= cmd_line_last;
        decim_q      <= cmd_decim;
        frame_idx    <= '0;
        decim_cnt    <= '0;
      end else begin
        if (frame_inc)
          frame_idx <= frame_idx + FRAME_ONE;
        if (frame_start) begin
          unique case (1'b1)
            skip_dec: decim_cnt <= decim_cnt - 4'd1;
            skip_drop: begin
              decim_cnt <= decim_q;
              if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            end
            take: decim_cnt <= decim_q;
            default: decim_cnt <= decim_cnt;
          endcase
        end
      end
      if (frame_start && take)
        first_pend <= 1'b1;
      else if (cap_word)
        first_pend <= 1'b0;
    end
  end

  // registered output word, one cycle behind the sampled beat
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= cap_word;
      if (cap_word)
        out_data <= {frame_idx, line_idx, clk_idx, flags, cl_data};
    end
  end

endmodule

// File: doc/cl_capture_sched.md
Name: cl_capture_sched

Overview:
Frame capture scheduler for the Camera Link input path, running entirely in the cl_clk domain. It accepts a capture command (frame count, line window, frame decimation) and gates the raw 80-bit CL beats into tagged 128-bit words for the downstream message FIFO. It also drops whole frames when the FIFO is near full, and reports done, abort and overflow status. Commands arrive already synchronized into cl_clk by the bus-side command logic.

Parameters:
N_FRAME_SIZE, 20, width of frame count and frame index
N_LINE_SIZE, 12, width of line counter and window bounds
N_CLK_SIZE, 10, width of per-line beat counter
DATA_W, 80, CL data width; out_data = N_FRAME_SIZE+N_LINE_SIZE+N_CLK_SIZE+6+DATA_W = 128 at defaults

Ports:
reset  in  1  asynchronous, active-high
cl_clk  in  1  Camera Link pixel clock; all logic on its rising edge
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_n_frames  in  N_FRAME_SIZE  frames to capture
cmd_line_first  in  N_LINE_SIZE  first captured line (0-based, inclusive)
cmd_line_last  in  N_LINE_SIZE  last captured line (inclusive)
cmd_decim  in  4  capture 1 frame, then skip cmd_decim frames
abort  in  1  terminate sequence
cl_fval, cl_lval  in  1 each  camera frame/line valid
cl_data  in  DATA_W  camera beat
fifo_afull  in  1  downstream almost-full
fifo_full  in  1  downstream full
out_data  out  128  {frame_idx, line_idx, clk_idx, flags[5:0], data}
out_valid  out  1  write strobe; no backpressure
done  out  1  1-cycle pulse at end of sequence
aborted  out  1  qualifies done
busy  out  1  state != IDLE
drop_cnt  out  16  frames dropped for afull, saturating
overflow  out  1  sticky: out_valid while fifo_full

Behaviour:
- Reset: every output 0, cmd_ready 0 only during reset. State IDLE. All counters 0.
- Edge detection: fval_d and lval_d are registered copies. Rise = in && !d. Fall = !in && d.
- IDLE:
  - Accept when cmd_valid && cmd_ready. Latch all fields. Clear overflow. Set frame_idx=0 and decim_cnt=0.
  - If n_frames==0, go to DONE; no data is emitted.
  - Otherwise go to ARMED.
- ARMED: wait until cl_fval is sampled low, so a partially started frame is never captured. Then go to WAIT_FV.
- WAIT_FV, on fval rise:
  - decim_cnt!=0: decrement decim_cnt, go to SKIP.
  - else fifo_afull: go to SKIP, drop_cnt++ (saturating), decim_cnt=cmd_decim.
  - else: go to CAPTURE, decim_cnt=cmd_decim.
- Counters:
  - line_idx clears on fval rise and increments on each lval fall.
  - clk_idx clears when lval is low and increments on each lval-high cycle; it wraps silently.
- CAPTURE output:
  - Registered, latency 1 cycle.
  - out_valid(t+1) = CAPTURE && cl_lval && line_first <= line_idx <= line_last at t.
  - line_first > line_last means an empty window: the frame still counts, but emits no words.
- Flags:
  - bit5: first word of frame.
  - bit4: first word of line (clk_idx==0).
  - bit3: last frame of sequence.
  - bit2: overflow, as updated by this word.
  - bits1:0: 0.
- Frame end (fval fall):
  - In CAPTURE: frame_idx++. If frame_idx+1==n_frames, go to DONE; else go to WAIT_FV.
  - In SKIP: go to WAIT_FV. Skipped or dropped frames never advance frame_idx.
- DONE: done=1 for one cycle, then IDLE.
- Abort:
  - Abort in any non-IDLE state goes to IDLE on the next edge, with done=1 and aborted=1 for that one cycle.
  - out_valid is 0 from the cycle after abort is sampled.
  - Abort in IDLE has no effect; abort has priority over every other transition.
  - A truncated frame does not advance frame_idx.
- Overflow: set when out_valid && fifo_full. The word is still emitted.
- Simultaneous fval fall and rise cannot occur. An fval rise seen in CAPTURE or SKIP (a missed fall) is treated as frame end followed by a new frame start.
- Reset mid-operation returns to IDLE immediately with no done pulse.

Decomposition:
- Shared package: state encoding (IDLE, ARMED, WAIT_FV, SKIP, CAPTURE, DONE), N_*_SIZE defaults, flag bit positions, and the 128-bit field offsets, so the PC-side decoder and the bus-side logic agree.
- One sub-module, cl_timing_cnt: fval/lval edge detection plus the line_idx and clk_idx counters. It is reusable by the capture datapath.

Test Plan:
1. n_frames=2, window 1..2, decim=0; frames of 4 lines x 3 beats -> exactly 12 words:
   - frame_idx 0,1; line_idx 1,2; clk_idx 0..2.
   - bit5 set on the first word of each frame; bit3 set in frame 1.
   - done pulse once.
2. Command accepted while fval is high mid-frame -> the partial frame is ignored and capture starts at the next fval rise.
3. n_frames=3, decim=2 over 9 camera frames -> camera frames 0, 3 and 6 are captured; done follows the 7th fval fall.
4. fifo_afull high at the first fval rise, then low -> drop_cnt=1, no words from that frame; the next frame is captured as frame_idx 0.
5. Abort asserted mid-line in CAPTURE -> out_valid 0 from the next cycle, done=aborted=1 for one cycle, cmd_ready=1.
6. fifo_full pulsed during a captured word -> overflow sticky at 1 with flag bit2 set on that word; overflow clears on the next command accept. Also n_frames=0 -> done with no data.
